mux_tree_pipe: RTL and testbench

Parametrised, pipelined N-to-1 selector for the mux test area. It generalises the registered 2:1 test top to NUM_INPUTS = 2^SEL_WIDTH lanes using a radix-2 tree with configurable register spacing. Each word carries its select bits down the tree. A valid/ready handshake with per-stage bubble collapsing lets the block sit between streaming producers and consumers in the datapath.

---
 rtl/mux_tests_pkg.sv | 30 +++
 rtl/mux_tree_level.sv | 75 +++++++
 rtl/mux_tree_pipe.sv | 101 ++++++++++
 tb/tb_mux_tree_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_tests_pkg.sv
// Shared helpers for the mux test area: default sizes, stage arithmetic and
// lane-slice helpers used by the selector tree.
package mux_tests_pkg;

   localparam int DEF_BIT_WIDTH  = 16;
   localparam int DEF_SEL_WIDTH  = 2;
   localparam int DEF_NUM_INPUTS = 1 << DEF_SEL_WIDTH;
   localparam int LANE_STRIDE    = DEF_BIT_WIDTH;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Input register plus one register per STAGE_EVERY levels, root always registered.
   function automatic int stages(input int sel_width, input int stage_every);
      return 1 + (sel_width + stage_every - 1) / stage_every;
   endfunction

   function automatic int lane_lo(input int lane, input int bit_width);
      return lane * bit_width;
   endfunction

endpackage

// File: rtl/mux_tree_level.sv
// One radix-2 level of the selector tree: IN_LANES words in, IN_LANES/2 out,
// steered by select bit 0; optionally registered with its own valid/advance.
module mux_tree_level
   import mux_tests_pkg::*;
#(
   parameter int BIT_WIDTH  = 16,
   parameter int IN_LANES   = 4,
   parameter int SEL_WIDTH  = 2,
   parameter bit REGISTERED = 1'b1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [IN_LANES*BIT_WIDTH-1:0]      in_data,
   input  logic [SEL_WIDTH-1:0]               in_sel,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [(IN_LANES/2)*BIT_WIDTH-1:0]  out_data,
   output logic [SEL_WIDTH-1:0]               out_sel,
   output logic                               out_valid,
   input  logic                               out_ready
);

   localparam int OUT_LANES = IN_LANES / 2;

   logic [OUT_LANES*BIT_WIDTH-1:0] pick_s;
   logic [SEL_WIDTH-1:0]           rest_sel_s;

   // Pairwise select; the consumed bit is shifted out so the next level sees its bit at 0.
   always_comb begin
      pick_s     = '0;
      rest_sel_s = in_sel >> 32'd1;
      for (int k = 0; k < OUT_LANES; k++) begin
         if (in_sel[0]) begin
            pick_s[lane_lo(k, BIT_WIDTH) +: BIT_WIDTH] = in_data[lane_lo(2 * k + 1, BIT_WIDTH) +: BIT_WIDTH];
         end else begin
            pick_s[lane_lo(k, BIT_WIDTH) +: BIT_WIDTH] = in_data[lane_lo(2 * k, BIT_WIDTH) +: BIT_WIDTH];
         end
      end
   end

   if (REGISTERED) begin : g_reg
      logic [OUT_LANES*BIT_WIDTH-1:0] data_r;
      logic [SEL_WIDTH-1:0]           sel_r;
      logic                           valid_r;
      logic                           load_s;

      assign load_s = !valid_r || out_ready;

      // Stage register: fills bubbles while downstream stalls; data only moves with a word.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            sel_r   <= '0;
         end else if (load_s) begin
            valid_r <= in_valid;
            if (in_valid) begin
               data_r <= pick_s;
               sel_r  <= rest_sel_s;
            end
         end
      end

      assign in_ready  = load_s;
      assign out_data  = data_r;
      assign out_sel   = sel_r;
      assign out_valid = valid_r;
   end else begin : g_comb
      assign in_ready  = out_ready;
      assign out_data  = pick_s;
      assign out_sel   = rest_sel_s;
      assign out_valid = in_valid;
   end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 lane selector with valid/ready flow control, bubble
// collapsing and a saturating count of delivered words.
module mux_tree_pipe
   import mux_tests_pkg::*;
#(
   parameter int  BIT_WIDTH   = 16,
   parameter int  SEL_WIDTH   = 2,
   localparam int NUM_INPUTS  = 1 << SEL_WIDTH,
   parameter int  STAGE_EVERY = 1,
   parameter int  CNT_WIDTH   = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_INPUTS*BIT_WIDTH-1:0] i_inputs,
   input  logic [SEL_WIDTH-1:0]            i_sel,
   input  logic                            i_valid,
   output logic                            o_ready,
   output logic [BIT_WIDTH-1:0]            o_outputs,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [CNT_WIDTH-1:0]            o_xfer_count
);

   logic [NUM_INPUTS*BIT_WIDTH-1:0] data0_r;
   logic [SEL_WIDTH-1:0]            sel0_r;
   logic                            valid0_r;
   logic                            load0_s;
   logic [CNT_WIDTH-1:0]            cnt_r;

   // Element l is the interface feeding tree level l; element SEL_WIDTH is the output side.
   logic                 valid_s [0:SEL_WIDTH];
   logic                 ready_s [0:SEL_WIDTH];
   logic [SEL_WIDTH-1:0] sel_s   [0:SEL_WIDTH];

   assign load0_s            = !valid0_r || ready_s[0];
   assign valid_s[0]         = valid0_r;
   assign sel_s[0]           = sel0_r;
   assign ready_s[SEL_WIDTH] = i_ready;

   // Input register: captures the whole lane bundle and its select on a handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid0_r <= 1'b0;
         data0_r  <= '0;
         sel0_r   <= '0;
      end else if (load0_s) begin
         valid0_r <= i_valid;
         if (i_valid) begin
            data0_r <= i_inputs;
            sel0_r  <= i_sel;
         end
      end
   end

   for (genvar l = 0; l < SEL_WIDTH; l++) begin : g_lvl
      localparam int IN_LANES = NUM_INPUTS >> l;
      localparam bit IS_REG   = (((l + 1) % STAGE_EVERY) == 0) || (l == SEL_WIDTH - 1);

      logic [IN_LANES*BIT_WIDTH-1:0]     d_in_s;
      logic [(IN_LANES/2)*BIT_WIDTH-1:0] d_out_s;

      if (l == 0) begin : g_first
         assign d_in_s = data0_r;
      end else begin : g_next
         assign d_in_s = g_lvl[l-1].d_out_s;
      end

      mux_tree_level #(
         .BIT_WIDTH  (BIT_WIDTH),
         .IN_LANES   (IN_LANES),
         .SEL_WIDTH  (SEL_WIDTH),
         .REGISTERED (IS_REG)
      ) u_level (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_data   (d_in_s),
         .in_sel    (sel_s[l]),
         .in_valid  (valid_s[l]),
         .in_ready  (ready_s[l]),
         .out_data  (d_out_s),
         .out_sel   (sel_s[l+1]),
         .out_valid (valid_s[l+1]),
         .out_ready (ready_s[l+1])
      );
   end

   // Output-handshake counter; sticks at all ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (o_valid && i_ready && (cnt_r != {CNT_WIDTH{1'b1}})) begin
         cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign o_ready      = load0_s;
   assign o_valid      = valid_s[SEL_WIDTH];
   assign o_outputs    = g_lvl[SEL_WIDTH-1].d_out_s;
   assign o_xfer_count = cnt_r;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: default build plus a SEL_WIDTH=3,
// STAGE_EVERY=2, 8-bit, 4-bit-counter build, both against a lane-index scoreboard.
module tb_mux_tree_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;

   logic [63:0] a_inputs = '0;
   logic [1:0]  a_sel = '0;
   logic        a_valid = 1'b0;
   logic        a_rdy = 1'b0;
   logic        a_o_ready;
   logic [15:0] a_out;
   logic        a_o_valid;
   logic [31:0] a_cnt;

   logic [63:0] b_inputs = '0;
   logic [2:0]  b_sel = '0;
   logic        b_valid = 1'b0;
   logic        b_rdy = 1'b0;
   logic        b_o_ready;
   logic [7:0]  b_out;
   logic        b_o_valid;
   logic [3:0]  b_cnt;

   mux_tree_pipe u_dut_a (
      .clk(clk), .rst_n(rst_n), .i_inputs(a_inputs), .i_sel(a_sel), .i_valid(a_valid),
      .o_ready(a_o_ready), .o_outputs(a_out), .o_valid(a_o_valid), .i_ready(a_rdy),
      .o_xfer_count(a_cnt)
   );

   mux_tree_pipe #(.BIT_WIDTH(8), .SEL_WIDTH(3), .STAGE_EVERY(2), .CNT_WIDTH(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_inputs(b_inputs), .i_sel(b_sel), .i_valid(b_valid),
      .o_ready(b_o_ready), .o_outputs(b_out), .o_valid(b_o_valid), .i_ready(b_rdy),
      .o_xfer_count(b_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: in-order queue of accepted lane values; occupancy decides readiness.
   logic [15:0] qa[$];
   logic [7:0]  qb[$];
   int          hs_a = 0;
   int          hs_b = 0;
   logic        stall_a = 1'b0;
   logic        stall_b = 1'b0;
   logic [15:0] held_a = '0;
   logic [7:0]  held_b = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         hs_a = 0;
         hs_b = 0;
         stall_a = 1'b0;
         stall_b = 1'b0;
      end else begin
         check("a_count", a_cnt, hs_a);
         check("a_ready", a_o_ready, (qa.size() < 3) || a_rdy);
         if (stall_a) begin
            check("a_hold_valid", a_o_valid, 1'b1);
            check("a_hold_data", a_out, held_a);
         end
         if (a_o_valid && a_rdy) begin
            if (qa.size() == 0) check("a_spurious_valid", a_o_valid, 1'b0);
            else check("a_data", a_out, qa.pop_front());
            hs_a++;
         end
         stall_a = a_o_valid && !a_rdy;
         held_a  = a_out;
         if (a_valid && a_o_ready) qa.push_back(a_inputs[a_sel*16 +: 16]);

         check("b_count", b_cnt, (hs_b > 15) ? 15 : hs_b);
         check("b_ready", b_o_ready, (qb.size() < 3) || b_rdy);
         if (stall_b) begin
            check("b_hold_valid", b_o_valid, 1'b1);
            check("b_hold_data", b_out, held_b);
         end
         if (b_o_valid && b_rdy) begin
            if (qb.size() == 0) check("b_spurious_valid", b_o_valid, 1'b0);
            else check("b_data", b_out, qb.pop_front());
            hs_b++;
         end
         stall_b = b_o_valid && !b_rdy;
         held_b  = b_out;
         if (b_valid && b_o_ready) qb.push_back(b_inputs[b_sel*8 +: 8]);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [15:0] words [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

   initial begin
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_a_valid", a_o_valid, 1'b0);
      check("rst_a_data", a_out, 16'h0000);
      check("rst_a_count", a_cnt, 32'd0);
      check("rst_a_ready", a_o_ready, 1'b1);
      check("rst_b_valid", b_o_valid, 1'b0);
      check("rst_b_ready", b_o_ready, 1'b1);

      // Streaming: one word per cycle, first result two cycles after capture.
      a_inputs = 64'hDDDD_CCCC_BBBB_AAAA;
      a_rdy = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         if (k <= 4) begin
            a_valid = 1'b1;
            a_sel = 2'(k - 1);
         end else begin
            a_valid = 1'b0;
         end
         tick();
         if (k >= 3 && k <= 6) begin
            check("stream_valid", a_o_valid, 1'b1);
            check("stream_data", a_out, words[k-3]);
         end else begin
            check("stream_idle", a_o_valid, 1'b0);
         end
      end
      check("stream_count", a_cnt, 32'd4);

      // Backpressure: three words fill the pipe, the fourth waits.
      a_rdy = 1'b0;
      for (int j = 0; j < 6; j++) begin
         a_valid = 1'b1;
         a_sel = 2'((j < 3) ? j : 3);
         check("bp_ready", a_o_ready, (j < 3) ? 1'b1 : 1'b0);
         tick();
      end
      check("bp_hold_valid", a_o_valid, 1'b1);
      check("bp_hold_data", a_out, 16'hAAAA);
      a_rdy = 1'b1;
      #1;
      check("bp_release_ready", a_o_ready, 1'b1);
      tick();
      a_valid = 1'b0;
      for (int j = 0; j < 4; j++) tick();
      check("bp_drain_count", a_cnt, 32'd8);
      check("bp_drain_idle", a_o_valid, 1'b0);

      // Bubble collapse: A, gap, B under stall end up back to back.
      a_rdy = 1'b0;
      a_valid = 1'b1; a_sel = 2'd0; tick();
      a_valid = 1'b0; tick();
      a_valid = 1'b1; a_sel = 2'd1; tick();
      a_valid = 1'b0; tick(); tick();
      check("bub_valid", a_o_valid, 1'b1);
      check("bub_data", a_out, 16'hAAAA);
      check("bub_ready", a_o_ready, 1'b1);
      a_rdy = 1'b1;
      tick();
      check("bub_next_valid", a_o_valid, 1'b1);
      check("bub_next_data", a_out, 16'hBBBB);
      tick();
      check("bub_empty", a_o_valid, 1'b0);

      // Reset with three words in flight.
      a_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_valid = 1'b1; a_sel = 2'(i + 1); tick();
      end
      a_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      check("mid_rst_valid", a_o_valid, 1'b0);
      check("mid_rst_data", a_out, 16'h0000);
      check("mid_rst_count", a_cnt, 32'd0);
      rst_n = 1'b1;
      a_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mid_rst_idle", a_o_valid, 1'b0);
      end

      // Second build: lane 5 of 0x17..0x10, three stages.
      b_inputs = 64'h1716_1514_1312_1110;
      b_rdy = 1'b1;
      b_valid = 1'b1; b_sel = 3'd5; tick();
      b_valid = 1'b0;
      check("b_lat1", b_o_valid, 1'b0);
      tick();
      check("b_lat2", b_o_valid, 1'b0);
      tick();
      check("b_lat3_valid", b_o_valid, 1'b1);
      check("b_lat3_data", b_out, 8'h15);
      tick();

      // Saturation: twenty more transfers on a 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         b_valid = 1'b1; b_sel = 3'(i); tick();
      end
      b_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("b_saturate", b_cnt, 4'd15);

      // Random lanes, selects and backpressure.
      for (int i = 0; i < 300; i++) begin
         b_inputs = {$urandom, $urandom};
         b_sel = 3'($urandom_range(7, 0));
         b_valid = 1'($urandom_range(1, 0));
         b_rdy = 1'($urandom_range(1, 0));
         tick();
      end
      b_valid = 1'b0;
      b_rdy = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("b_final_idle", b_o_valid, 1'b0);
      check("b_final_count", b_cnt, 4'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
